// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, operation kind and address-alignment helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } dmem_op_t;

    localparam int          CNT_W         = 3;
    localparam logic [1:0]  MISALIGN_MASK = 2'b11;
    localparam logic [15:0] WRCOUNT_MAX   = 16'hFFFF;

    function automatic logic is_misaligned(input logic [31:0] adr);
        return (adr[1:0] & MISALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Store/load bus between the core and the data-memory responder,
// including the committed-write observation signals.
interface dmem_responder_if;

    logic        memwrite;
    logic        memread;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready;
    logic        busy;
    logic        misaligned;
    logic [15:0] wrcount;
    logic [31:0] lastwaddr;
    logic [31:0] lastwdata;

    modport master (
        output memwrite, memread, dataadr, writedata,
        input  readdata, ready, busy, misaligned, wrcount, lastwaddr, lastwdata
    );

    modport slave (
        input  memwrite, memread, dataadr, writedata,
        output readdata, ready, busy, misaligned, wrcount, lastwaddr, lastwdata
    );

endinterface

// File: rtl/dmem_ram.sv
// Word-addressed 32-bit storage: synchronous write, combinational read.
// Deliberately unreset so contents survive a responder reset.
module dmem_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency load/store service with a one-cycle
// ready pulse and a committed-store observation port.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

    dmem_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    dmem_op_t         op_reg, op_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic             misaligned_reg, misaligned_next;
    logic [15:0]      wrcount_reg, wrcount_next;
    logic [31:0]      lastwaddr_reg, lastwaddr_next;
    logic [31:0]      lastwdata_reg, lastwdata_next;

    logic        req;
    logic        addr_ok;
    logic        in_resp;
    logic        commit_wr;
    logic [31:0] ram_rdata;

    assign req       = bus.memwrite | bus.memread;
    assign addr_ok   = !is_misaligned(addr_reg);
    assign in_resp   = (state_reg == RESP);
    // Misaligned stores are suppressed entirely: no RAM write, no observer update.
    assign commit_wr = in_resp && (op_reg == OP_WRITE) && addr_ok;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (commit_wr),
        .addr  (addr_reg[AW+1:2]),
        .wdata (wdata_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            op_reg         <= OP_READ;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            misaligned_reg <= 1'b0;
            wrcount_reg    <= '0;
            lastwaddr_reg  <= '0;
            lastwdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            op_reg         <= op_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            misaligned_reg <= misaligned_next;
            wrcount_reg    <= wrcount_next;
            lastwaddr_reg  <= lastwaddr_next;
            lastwdata_reg  <= lastwdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        op_next         = op_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        misaligned_next = misaligned_reg;
        wrcount_next    = wrcount_reg;
        lastwaddr_next  = lastwaddr_reg;
        lastwdata_next  = lastwdata_reg;

        case (state_reg)
            IDLE: begin
                if (req) begin
                    // A simultaneous read+write request is treated as a store.
                    op_next    = bus.memwrite ? OP_WRITE : OP_READ;
                    addr_next  = bus.dataadr;
                    wdata_next = bus.writedata;
                    cnt_next   = LAT_CNT;
                    state_next = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg <= 1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                if (!addr_ok) begin
                    misaligned_next = 1'b1;
                end
                if (commit_wr) begin
                    lastwaddr_next = addr_reg;
                    lastwdata_next = wdata_reg;
                    if (wrcount_reg != WRCOUNT_MAX) begin
                        wrcount_next = wrcount_reg + 16'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ready      = in_resp;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.readdata   = (in_resp && (op_reg == OP_READ) && addr_ok) ? ram_rdata : 32'd0;
    assign bus.misaligned = misaligned_reg;
    assign bus.wrcount    = wrcount_reg;
    assign bus.lastwaddr  = lastwaddr_reg;
    assign bus.lastwdata  = lastwdata_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus random traffic
// against a word-array model; a second instance exercises zero latency.
module tb_dmem_responder;

    localparam int LAT_A = 2;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    dmem_responder_if ia();
    dmem_responder_if ib();

    dmem_responder #(.DEPTH(64), .LATENCY(LAT_A)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ia)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(0)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ib)
    );

    typedef struct {
        logic [31:0] addr;
        bit          is_wr;
        bit          chk_rd;
        logic [31:0] rdata;
        logic [15:0] wrc;
        logic [31:0] lwa;
        logic [31:0] lwd;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model: plain word array addressed modulo 64 words.
    logic [31:0] mdl_mem [64];
    bit          mdl_known [64];
    logic [15:0] mdl_wrc;
    logic [31:0] mdl_lwa;
    logic [31:0] mdl_lwd;
    logic        mdl_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mdl_wrc = 16'd0;
        mdl_lwa = 32'd0;
        mdl_lwd = 32'd0;
        mdl_mis = 1'b0;
    endtask

    task automatic model_access(input bit we, input logic [31:0] adr, input logic [31:0] d,
                                output exp_t e);
        int idx;
        bit mis;
        idx      = int'((adr / 4) % 64);
        mis      = (adr % 4) != 0;
        e.addr   = adr;
        e.is_wr  = we;
        e.chk_rd = 1'b1;
        e.rdata  = 32'd0;
        if (mis) mdl_mis = 1'b1;
        if (we) begin
            if (!mis) begin
                mdl_mem[idx]   = d;
                mdl_known[idx] = 1'b1;
                if (mdl_wrc != 16'hFFFF) mdl_wrc = mdl_wrc + 16'd1;
                mdl_lwa = adr;
                mdl_lwd = d;
            end
        end else if (!mis) begin
            if (mdl_known[idx]) e.rdata = mdl_mem[idx];
            else                e.chk_rd = 1'b0;
        end
        e.wrc = mdl_wrc;
        e.lwa = mdl_lwa;
        e.lwd = mdl_lwd;
        e.mis = mdl_mis;
    endtask

    // Monitor: pops one expectation per ready pulse, checks the observer port
    // on the following cycle, and insists readdata is 0 outside ready.
    bit   obs_pending = 1'b0;
    exp_t obs_exp;

    always @(negedge clk) begin
        if (rst_a) begin
            obs_pending = 1'b0;
        end else begin
            if (obs_pending) begin
                chk("wrcount",    {16'd0, ia.wrcount}, {16'd0, obs_exp.wrc});
                chk("lastwaddr",  ia.lastwaddr, obs_exp.lwa);
                chk("lastwdata",  ia.lastwdata, obs_exp.lwd);
                chk("misaligned", {31'd0, ia.misaligned}, {31'd0, obs_exp.mis});
                obs_pending = 1'b0;
            end
            if (ia.ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got ready=1 expected no pending request");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.chk_rd) chk("readdata", ia.readdata, e.rdata);
                    obs_exp     = e;
                    obs_pending = 1'b1;
                    txn++;
                    $display("txn %0d: %s addr=%h readdata=%h wrcount=%0d", txn,
                             e.is_wr ? "store" : "load ", e.addr, ia.readdata, e.wrc);
                end
            end else begin
                chk("readdata_idle", ia.readdata, 32'd0);
            end
        end
    end

    task automatic access_a(input bit we, input bit re, input logic [31:0] adr,
                            input logic [31:0] d);
        exp_t e;
        int   n;
        bit   got;
        model_access(we, adr, d, e);
        sb.push_back(e);
        ia.memwrite  = we;
        ia.memread   = re;
        ia.dataadr   = adr;
        ia.writedata = d;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            chk("busy_inflight", {31'd0, ia.busy}, 32'd1);
            if (ia.ready) got = 1'b1;
        end
        chk("ready_latency", n, LAT_A + 1);
        ia.memwrite = 1'b0;
        ia.memread  = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_single", {31'd0, ia.ready}, 32'd0);
        chk("busy_idle",    {31'd0, ia.busy},  32'd0);
    endtask

    task automatic chk_outputs_zero_a(input string tag);
        chk({tag, "_ready"},      {31'd0, ia.ready},      32'd0);
        chk({tag, "_busy"},       {31'd0, ia.busy},       32'd0);
        chk({tag, "_readdata"},   ia.readdata,            32'd0);
        chk({tag, "_misaligned"}, {31'd0, ia.misaligned}, 32'd0);
        chk({tag, "_wrcount"},    {16'd0, ia.wrcount},    32'd0);
        chk({tag, "_lastwaddr"},  ia.lastwaddr,           32'd0);
        chk({tag, "_lastwdata"},  ia.lastwdata,           32'd0);
    endtask

    initial begin
        logic [31:0] bdata;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.memwrite = 1'b0; ia.memread = 1'b0; ia.dataadr = '0; ia.writedata = '0;
        ib.memwrite = 1'b0; ib.memread = 1'b0; ib.dataadr = '0; ib.writedata = '0;
        for (int i = 0; i < 64; i++) mdl_known[i] = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero_a("reset");
        chk("reset_b_ready",   {31'd0, ib.ready}, 32'd0);
        chk("reset_b_wrcount", {16'd0, ib.wrcount}, 32'd0);
        rst_a = 1'b0;

        // Directed scenarios.
        access_a(1'b1, 1'b0, 32'd16,  32'hbbaab2d6);
        access_a(1'b0, 1'b1, 32'd16,  32'd0);
        access_a(1'b0, 1'b1, 32'd272, 32'd0);
        access_a(1'b1, 1'b0, 32'd18,  32'h5);
        access_a(1'b0, 1'b1, 32'd16,  32'd0);
        access_a(1'b1, 1'b1, 32'd20,  32'h5);
        access_a(1'b1, 1'b0, 32'd24,  32'h11111111);

        // Store to 24 interrupted by reset during WAIT: must be dropped.
        ia.memwrite  = 1'b1;
        ia.dataadr   = 32'd24;
        ia.writedata = 32'hdeadbeef;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, ia.busy}, 32'd1);
        rst_a = 1'b1;
        #1;
        chk_outputs_zero_a("abort");
        @(posedge clk);
        #1;
        chk("abort_ready", {31'd0, ia.ready}, 32'd0);
        ia.memwrite = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready2", {31'd0, ia.ready}, 32'd0);
        rst_a = 1'b0;
        model_reset();
        access_a(1'b0, 1'b1, 32'd24, 32'd0);

        // Fill every word, then random mixed traffic.
        for (int i = 0; i < 64; i++) access_a(1'b1, 1'b0, 32'(i * 4), $urandom);
        for (int i = 0; i < 40; i++) begin
            int          op;
            logic [31:0] adr;
            op  = int'($urandom_range(0, 2));
            adr = $urandom_range(0, 1023);
            if ($urandom_range(0, 4) != 0) adr = adr & ~32'd3;
            access_a(op != 0, op != 1, adr, $urandom);
        end

        // Zero latency with a continuously held store request.
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        bdata = $urandom;
        ib.memwrite  = 1'b1;
        ib.dataadr   = 32'd40;
        ib.writedata = bdata;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            chk("lat0_ready", {31'd0, ib.ready}, 32'(i % 2));
        end
        ib.memwrite = 1'b0;
        chk("lat0_wrcount",    {16'd0, ib.wrcount}, 32'd4);
        chk("lat0_lastwaddr",  ib.lastwaddr, 32'd40);
        chk("lat0_lastwdata",  ib.lastwdata, bdata);
        chk("lat0_misaligned", {31'd0, ib.misaligned}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS core's store/load port. It accepts `memwrite`/`memread` requests with `dataadr`/`writedata` from `top` and services them after a fixed, parameterised number of wait states. It signals completion with a `ready` pulse and returns `readdata` for loads. It also exposes a committed-write observation port (last address/data, write count, misalignment flag) so benches can check stores directly instead of snooping the bus.

## Interface
- `DEPTH`, 64: number of 32-bit words; must be a power of two.
- `LATENCY`, 2: wait cycles between request acceptance and completion; legal range 0..7.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `memwrite` in 1: store request; held by the requester until `ready`.
- `memread` in 1: load request; held by the requester until `ready`.
- `dataadr` in 32: byte address.
- `writedata` in 32: store data.
- `readdata` out 32: load data; valid only in the `ready` cycle.
- `ready` out 1: one-cycle completion pulse.
- `busy` out 1: high while a request is in flight (WAIT or RESP).
- `misaligned` out 1: sticky; set by any access with `dataadr[1:0] != 0`.
- `wrcount` out 16: number of committed stores; saturates at 0xFFFF.
- `lastwaddr` out 32: byte address of the most recent committed store.
- `lastwdata` out 32: data of the most recent committed store.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `memwrite | memread` is high, latch the op, `dataadr` and `writedata`, and set the counter to LATENCY.
  - Next state is WAIT, or RESP if LATENCY == 0.
- WAIT: decrement the counter. When the counter is 1, next state is RESP.
- RESP:
  - Perform the access: `ready` = 1, then return to IDLE.
  - Store: write RAM[word index], update `lastwaddr`/`lastwdata`, increment `wrcount`.
  - Load: `readdata` = RAM[word index].
- Word index is `dataadr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- If `memwrite` and `memread` are high together, the access is a store. `readdata` = 0 that cycle.
- Misaligned access:
  - Still completes with `ready` in the normal cycle.
  - A store is suppressed: no RAM write, no observer update.
  - A load returns 0.
  - `misaligned` sets and stays set until reset.
- Request inputs are ignored while `busy`. Inputs are sampled only in IDLE.
- After `ready`, the FSM returns to IDLE. A still-asserted request is accepted as a new access on that IDLE cycle.
- Reset, including mid-operation:
  - FSM goes to IDLE and any in-flight store is dropped.
  - Outputs are 0: `readdata`, `ready`, `busy`, `misaligned`, `wrcount`, `lastwaddr`, `lastwdata`.
  - RAM contents are not reset; they are retained across reset and undefined at power-up.

## Timing
- Request first seen high in IDLE in cycle 0 → `ready` high in cycle LATENCY+1 → IDLE in cycle LATENCY+2.
- Minimum request-to-request spacing is LATENCY+2 cycles.
- `busy` is high from cycle 1 through cycle LATENCY+1.
- RAM write and observer registers update at the end of the RESP cycle. They are visible from cycle LATENCY+2.
- `readdata` is driven combinationally from RAM during RESP, and is 0 in every other cycle.
- `ready` and `busy` are registered-state decodes, with no combinational path from the request inputs.

## Structure
- Package `dmem_pkg` holds:
  - `dmem_state_t` (IDLE/WAIT/RESP).
  - `dmem_op_t` (OP_READ/OP_WRITE).
  - The LATENCY counter width constant (3).
  - The misalignment mask constant (2'b11).
- Sub-module `dmem_ram`: DEPTH×32 array with synchronous write enable and combinational read; no reset.
- The top level contains the FSM, request latches and observer registers.

## Test plan
- Reset held for 2 cycles, LATENCY=2, store 0xbbaab2d6 to address 16:
  - `ready` pulses exactly 3 cycles after the request.
  - Afterwards `wrcount`=1, `lastwaddr`=16, `lastwdata`=0xbbaab2d6.
- Load from address 16:
  - `readdata`=0xbbaab2d6 in the `ready` cycle, and 0 one cycle before and one cycle after.
- DEPTH=64, load from address 272 (16+256):
  - Returns 0xbbaab2d6, showing wrap-around.
- Store 0x5 to address 18:
  - `ready` pulses.
  - `misaligned`=1 and stays 1 through later accesses.
  - `wrcount` is unchanged, and a load from 16 still returns 0xbbaab2d6.
- `memwrite` and `memread` together, address 20, data 0x5:
  - The store commits and `readdata`=0.
  - Then a store to 24 with reset asserted during WAIT: `ready` never pulses, all outputs are 0, and a later load from 24 returns its prior contents.
- LATENCY=0 with a continuously held request:
  - `ready` pulses every second cycle.
  - 4 stores complete in 8 cycles and `wrcount`=4.
